// File: rtl/laser_scan.sv
// rtl/laser_scan.sv - two-circle greedy coverage search over a 2^CW x 2^CW grid
module laser_scan #(
  parameter int            NPTS    = 40,
  parameter int            CW      = 4,
  parameter logic [2*CW:0] R2      = (2*CW+1)'(16),
  parameter int            MAXPASS = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  output logic          IN_READY,
  output logic [CW-1:0] C1X,
  output logic [CW-1:0] C1Y,
  output logic [CW-1:0] C2X,
  output logic [CW-1:0] C2Y,
  output logic [7:0]    COVER,
  output logic          DONE
);

  localparam int PW = (NPTS > 1) ? $clog2(NPTS) : 1;

  typedef enum logic [2:0] {LOAD, SCAN1, SCAN2, EVAL, FINISH} state_e;

  state_e           state_q;
  logic [PW-1:0]    load_cnt_q;
  logic [PW-1:0]    pt_q;
  logic [2*CW-1:0]  cand_q;
  logic [7:0]       acc_q;
  logic [7:0]       best_q;
  logic [7:0]       start_best_q;
  logic [3:0]       pass_q;
  logic [CW-1:0]    w1x_q, w1y_q, w2x_q, w2y_q;
  logic [CW-1:0]    c1x_q, c1y_q, c2x_q, c2y_q;
  logic [7:0]       cover_q;
  logic             done_q;
  logic             in_ready_q;

  logic [CW-1:0]    px_mem [NPTS];
  logic [CW-1:0]    py_mem [NPTS];

  logic [CW-1:0]    px, py, fx, fy, cx, cy;
  logic             hit, xfer;
  logic [7:0]       acc_d;

  function automatic logic covers(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                  input logic [CW-1:0] bx, input logic [CW-1:0] by);
    logic [CW-1:0]   dx, dy;
    logic [2*CW-1:0] sx, sy;
    logic [2*CW:0]   sum;
    dx  = (ax > bx) ? ax - bx : bx - ax;
    dy  = (ay > by) ? ay - by : by - ay;
    sx  = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
    sy  = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
    sum = {1'b0, sx} + {1'b0, sy};
    return sum <= R2;
  endfunction

  // SCAN1 holds w2 fixed, SCAN2 holds w1 fixed; candidate is y-major
  assign fx    = (state_q == SCAN1) ? w2x_q : w1x_q;
  assign fy    = (state_q == SCAN1) ? w2y_q : w1y_q;
  assign cx    = cand_q[CW-1:0];
  assign cy    = cand_q[2*CW-1:CW];
  assign px    = px_mem[pt_q];
  assign py    = py_mem[pt_q];
  assign hit   = covers(px, py, cx, cy) || covers(px, py, fx, fy);
  assign acc_d = acc_q + {7'd0, hit};
  assign xfer  = IN_VALID && in_ready_q;

  always_ff @(posedge CLK) begin
    if (xfer) begin
      px_mem[load_cnt_q] <= X;
      py_mem[load_cnt_q] <= Y;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= LOAD;
      load_cnt_q   <= '0;
      pt_q         <= '0;
      cand_q       <= '0;
      acc_q        <= '0;
      best_q       <= '0;
      start_best_q <= '0;
      pass_q       <= '0;
      w1x_q        <= '0;
      w1y_q        <= '0;
      w2x_q        <= '0;
      w2y_q        <= '0;
      c1x_q        <= '0;
      c1y_q        <= '0;
      c2x_q        <= '0;
      c2y_q        <= '0;
      cover_q      <= '0;
      done_q       <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (xfer) begin
            if (load_cnt_q == PW'(NPTS - 1)) begin
              load_cnt_q   <= '0;
              in_ready_q   <= 1'b0;
              state_q      <= SCAN1;
              pt_q         <= '0;
              cand_q       <= '0;
              acc_q        <= '0;
              best_q       <= '0;
              start_best_q <= '0;
              pass_q       <= 4'd1;
              w1x_q        <= '0;
              w1y_q        <= '0;
              w2x_q        <= '0;
              w2y_q        <= '0;
            end else begin
              load_cnt_q <= load_cnt_q + PW'(1);
            end
          end
        end
        SCAN1, SCAN2: begin
          if (pt_q == PW'(NPTS - 1)) begin
            pt_q   <= '0;
            acc_q  <= '0;
            cand_q <= cand_q + (2*CW)'(1);
            // strict greater-than keeps the earliest candidate on ties
            if (acc_d > best_q) begin
              best_q <= acc_d;
              if (state_q == SCAN1) begin
                w1x_q <= cx;
                w1y_q <= cy;
              end else begin
                w2x_q <= cx;
                w2y_q <= cy;
              end
            end
            if (cand_q == '1) state_q <= (state_q == SCAN1) ? SCAN2 : EVAL;
          end else begin
            pt_q  <= pt_q + PW'(1);
            acc_q <= acc_d;
          end
        end
        EVAL: begin
          if (best_q == start_best_q || pass_q == 4'(MAXPASS) || best_q == 8'(NPTS)) begin
            state_q <= FINISH;
            c1x_q   <= w1x_q;
            c1y_q   <= w1y_q;
            c2x_q   <= w2x_q;
            c2y_q   <= w2y_q;
            cover_q <= best_q;
            done_q  <= 1'b1;
          end else begin
            pass_q       <= pass_q + 4'd1;
            start_best_q <= best_q;
            state_q      <= SCAN1;
          end
        end
        FINISH: begin
          state_q    <= LOAD;
          in_ready_q <= 1'b1;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign IN_READY = in_ready_q;
  assign C1X      = c1x_q;
  assign C1Y      = c1y_q;
  assign C2X      = c2x_q;
  assign C2Y      = c2y_q;
  assign COVER    = cover_q;
  assign DONE     = done_q;

endmodule

// File: doc/laser_scan.md
LASER_SCAN -- requirements
Module: laser_scan

Interface
REQ-001 SHALL have parameter NPTS, default 40: points per frame, range 2..255.
REQ-002 SHALL have parameter CW, default 4: coordinate width; the grid is 2^CW x 2^CW.
REQ-003 SHALL have parameter R2, default 16: squared coverage radius, unsigned, width 2*CW+1.
REQ-004 SHALL have parameter MAXPASS, default 8: maximum SCAN1+SCAN2 pass pairs, range 1..15.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port IN_VALID, input, 1 bit: X/Y carry a point this cycle.
REQ-008 SHALL have port X, input, CW bits: point x coordinate.
REQ-009 SHALL have port Y, input, CW bits: point y coordinate.
REQ-010 SHALL have port IN_READY, output, 1 bit: block accepts points; high only in LOAD.
REQ-011 SHALL have ports C1X, C1Y, C2X and C2Y, output, CW bits each: result circle centres.
REQ-012 SHALL have port COVER, output, 8 bits: points covered by the union of both circles.
REQ-013 SHALL have port DONE, output, 1 bit: one-cycle pulse when results are valid.

Function
REQ-014 SHALL have FSM states LOAD, SCAN1, SCAN2, EVAL and FINISH.
REQ-015 SHALL treat IN_VALID & IN_READY as a transfer and store the point at index load_cnt; load_cnt increments per transfer.
REQ-016 SHALL ignore IN_VALID outside LOAD and never overwrite stored points there.
REQ-017 SHALL move LOAD->SCAN1 on the transfer with load_cnt == NPTS-1.
REQ-018 SHALL define a point covered by centre (cx,cy) iff (x-cx)^2 + (y-cy)^2 <= R2.
REQ-019 SHALL compute each square at full 2*CW-bit precision using absolute differences; the sum is 2*CW+1 bits with no truncation.
REQ-020 SHALL have an internal working pair (w1,w2), initialised to (0,0),(0,0) on entry to SCAN1 from LOAD; best_cnt initialises to 0.
REQ-021 SHALL in SCAN1 visit every candidate c in raster order (y outer, x inner, 0..2^CW-1) with w2 fixed.
REQ-022 SHALL for each SCAN1 candidate evaluate one stored point per cycle over NPTS cycles, counting points covered by c OR by w2.
REQ-023 SHALL in SCAN1, when a candidate count is strictly greater than best_cnt, set w1 := c and best_cnt := count; ties keep the earlier candidate.
REQ-024 SHALL run SCAN2 identically to SCAN1 with w1 fixed, updating w2 under the same strict-greater rule against the same best_cnt.
REQ-025 SHALL make each scan take exactly 2^(2*CW) * NPTS cycles, with no idle cycles between candidates.
REQ-026 SHALL in EVAL, lasting one cycle, compare best_cnt with its value at the start of the pass pair.
REQ-027 SHALL in EVAL go to FINISH if best_cnt did not increase, if pass_cnt == MAXPASS, or if best_cnt == NPTS; otherwise increment pass_cnt and go to SCAN1.
REQ-028 SHALL in FINISH, lasting one cycle, drive C1=w1, C2=w2 and COVER=best_cnt, assert DONE for exactly that cycle, and go to LOAD.
REQ-029 SHALL hold C1X/C1Y/C2X/C2Y/COVER stable from FINISH until the next FINISH; DONE is low in all other states.
REQ-030 SHALL let the next frame's first point transfer in the cycle after DONE.
REQ-031 SHALL size the candidate counter and the point counter so they do not wrap mid-scan for maximal parameters.

Reset
REQ-032 SHALL when RST_N is low at a rising edge, in any state, enter LOAD and clear load_cnt, pass_cnt, best_cnt, w1 and w2.
REQ-033 SHALL on that reset edge drive C1X=C1Y=C2X=C2Y=0, COVER=0 and DONE=0; IN_READY is high the cycle after RST_N returns high.
REQ-034 SHALL discard any partial frame or scan interrupted by reset; stored point contents need no reset.

Verification
REQ-035 SHALL be verified by scenario: 40 points all at (3,3), default parameters -> C1=(1,0), C2=(0,0), COVER=40, DONE one cycle.
REQ-036 SHALL be verified by scenario: 20 points at (2,2) and 20 at (13,13) -> C1=(13,9), C2=(0,0), COVER=40.
REQ-037 SHALL be verified by scenario: 40 points at (15,15) with R2=0 -> C1=(15,15), C2=(0,0), COVER=40; the exact-distance boundary is included.
REQ-038 SHALL be verified by scenario: IN_VALID toggling every other cycle during LOAD and held high during SCAN -> exactly 40 points captured, results identical to the gap-free run.
REQ-039 SHALL be verified by scenario: RST_N pulsed low mid-SCAN2, then a fresh frame -> no DONE for the aborted frame, outputs 0, the fresh frame's results are correct.
REQ-040 SHALL be verified by scenario: NPTS=8, CW=3, MAXPASS=1 -> DONE exactly 2*64*8+2 cycles after the last point transfer.
